// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader: sweeps data_mem word addresses while holding the CPU in
// reset, and streams each word read (with its byte address) out on a
// valid/ready interface.
module dmem_dump_reader #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             cpu_hold,
    output logic [31:0]      rd_addr,
    input  logic [31:0]      rd_data,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [31:0]      dout_data,
    output logic [31:0]      dout_addr,
    output logic             busy,
    output logic             done
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_READ,
        S_OUT,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             hold_q, hold_d;
    logic             valid_q, valid_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      oaddr_q, oaddr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and registered-output computation for the dump sequencer
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        hold_d   = hold_q;
        valid_d  = valid_q;
        data_d   = data_q;
        oaddr_d  = oaddr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = {base_addr[31:2], 2'b00};
                    cnt_d  = word_count;
                    busy_d = 1'b1;
                    if (word_count == '0) begin
                        // Empty dump: never touch the memory or the CPU
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_SETTLE;
                        hold_d   = 1'b1;
                        settle_d = '0;
                    end
                end
            end
            S_SETTLE: begin
                // Give the CPU address mux time to switch to our address
                if (settle_q == SETTLE_LAST) state_d = S_READ;
                else                         settle_d = settle_q + SW'(1);
            end
            S_READ: begin
                data_d  = rd_data;
                oaddr_d = addr_q;
                valid_d = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (dout_ready) begin
                    valid_d = 1'b0;
                    addr_d  = addr_q + 32'd4;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q > CNT_W'(1)) begin
                        state_d = S_READ;
                    end else begin
                        // Release the CPU on the last handshake edge
                        state_d = S_FIN;
                        hold_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                hold_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                hold_d  = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any dump in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            hold_q   <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            oaddr_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            hold_q   <= hold_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            oaddr_q  <= oaddr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cpu_hold   = hold_q;
    assign rd_addr    = hold_q ? addr_q : 32'd0;
    assign dout_valid = valid_q;
    assign dout_data  = data_q;
    assign dout_addr  = oaddr_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed bench for dmem_dump_reader. Memory model: word at byte address a
// holds (a>>2)-6, so 0x40/0x44/0x48 hold 0xA/0xB/0xC.
module tb_dmem_dump_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        cpu_hold;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;
    logic [31:0] dout_addr;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [31:0] hs_addr[$];
    logic [31:0] hs_data[$];
    int          hs_cyc[$];
    int          done_cnt, done_cyc, hold_seen, valid_seen, hold_fall_cyc, idle_hold, cyc;
    logic        hold_prev;

    always #5 clk = ~clk;

    assign rd_data = (rd_addr >> 2) - 32'd6;

    dmem_dump_reader #(.SETTLE_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .cpu_hold(cpu_hold), .rd_addr(rd_addr),
        .rd_data(rd_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_data(dout_data), .dout_addr(dout_addr), .busy(busy), .done(done)
    );

    task automatic clear_obs();
        hs_addr.delete(); hs_data.delete(); hs_cyc.delete();
        done_cnt = 0; done_cyc = -1; hold_seen = 0; valid_seen = 0;
        hold_fall_cyc = -1; idle_hold = 0; cyc = 0; hold_prev = 1'b0;
    endtask

    // Record what the DUT shows in the current cycle (called at negedge,
    // after any input changes for this cycle have been applied)
    task automatic observe();
        cyc++;
        if (dout_valid && dout_ready) begin
            hs_addr.push_back(dout_addr);
            hs_data.push_back(dout_data);
            hs_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cpu_hold) hold_seen++;
        if (dout_valid) valid_seen++;
        if (cpu_hold && !busy) idle_hold++;
        if (hold_prev && !cpu_hold && hold_fall_cyc < 0) hold_fall_cyc = cyc;
        hold_prev = cpu_hold;
    endtask

    task automatic kick(input logic [31:0] b, input logic [15:0] n);
        @(negedge clk);
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        clear_obs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_hold, dout_valid, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got hold=%b valid=%b busy=%b done=%b want all 0",
                     cpu_hold, dout_valid, busy, done);
        end
        checks++;
        if (rd_addr !== 32'd0) begin
            errors++; $display("FAIL reset_rd_addr got %h want 0", rd_addr);
        end
        checks++;
        if (dout_data !== 32'd0 || dout_addr !== 32'd0) begin
            errors++; $display("FAIL reset_dout got data=%h addr=%h want 0", dout_data, dout_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        dout_ready = 1'b1;
        kick(32'h40, 16'd3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            observe();
            if (cyc == 1) begin
                checks++;
                if (!cpu_hold || rd_addr !== 32'h40) begin
                    errors++;
                    $display("FAIL basic_settle got hold=%b rd_addr=%h want 1/00000040", cpu_hold, rd_addr);
                end
            end
        end
        checks++;
        if (hs_addr.size() != 3) begin
            errors++; $display("FAIL basic_count got %0d want 3", hs_addr.size());
        end else begin
            checks++;
            if (hs_addr[0] !== 32'h40 || hs_data[0] !== 32'hA) begin
                errors++; $display("FAIL basic_w0 got %h/%h want 00000040/0000000a", hs_addr[0], hs_data[0]);
            end
            checks++;
            if (hs_addr[1] !== 32'h44 || hs_data[1] !== 32'hB) begin
                errors++; $display("FAIL basic_w1 got %h/%h want 00000044/0000000b", hs_addr[1], hs_data[1]);
            end
            checks++;
            if (hs_addr[2] !== 32'h48 || hs_data[2] !== 32'hC) begin
                errors++; $display("FAIL basic_w2 got %h/%h want 00000048/0000000c", hs_addr[2], hs_data[2]);
            end
            checks++;
            if (hs_cyc[1] - hs_cyc[0] != 2 || hs_cyc[2] - hs_cyc[1] != 2) begin
                errors++; $display("FAIL basic_rate got gaps %0d,%0d want 2,2",
                                   hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
            end
            checks++;
            if (hold_fall_cyc != hs_cyc[2] + 1) begin
                errors++; $display("FAIL basic_hold_fall got cycle %0d want %0d", hold_fall_cyc, hs_cyc[2] + 1);
            end
            checks++;
            if (done_cyc != hs_cyc[2] + 1) begin
                errors++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, hs_cyc[2] + 1);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt);
        end
        checks++;
        if (busy !== 1'b0 || idle_hold != 0) begin
            errors++; $display("FAIL basic_idle got busy=%b idle_hold=%0d want 0/0", busy, idle_hold);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0, a0;
        int low;
        int first_valid;
        low = 0; first_valid = -1; d0 = '0; a0 = '0;
        dout_ready = 1'b0;
        kick(32'h100, 16'd2);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (dout_valid && hs_addr.size() == 0 && !dout_ready) begin
                if (low == 0) begin
                    d0 = dout_data; a0 = dout_addr; first_valid = cyc + 1;
                end else begin
                    checks++;
                    if (dout_data !== d0 || dout_addr !== a0) begin
                        errors++; $display("FAIL bp_stable got %h/%h want %h/%h", dout_addr, dout_data, a0, d0);
                    end
                end
                low++;
                if (low == 6) dout_ready = 1'b1;
            end
            observe();
        end
        checks++;
        if (hs_addr.size() != 2) begin
            errors++; $display("FAIL bp_count got %0d want 2", hs_addr.size());
        end else begin
            checks++;
            if (hs_addr[0] !== 32'h100 || hs_data[0] !== 32'h3A || hs_addr[1] !== 32'h104 || hs_data[1] !== 32'h3B) begin
                errors++; $display("FAIL bp_words got %h/%h %h/%h want 00000100/0000003a 00000104/0000003b",
                                   hs_addr[0], hs_data[0], hs_addr[1], hs_data[1]);
            end
            checks++;
            if (hs_cyc[0] - first_valid != 5) begin
                errors++; $display("FAIL bp_wait got %0d low cycles want 5", hs_cyc[0] - first_valid);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL bp_done got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_zero_count();
        dout_ready = 1'b1;
        kick(32'h80, 16'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b0;
            observe();
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 1) begin
            errors++; $display("FAIL zero_done got cnt=%0d cycle=%0d want 1/1", done_cnt, done_cyc);
        end
        checks++;
        if (hold_seen != 0 || valid_seen != 0) begin
            errors++; $display("FAIL zero_quiet got hold=%0d valid=%0d want 0/0", hold_seen, valid_seen);
        end
    endtask

    task automatic test_wrap();
        dout_ready = 1'b1;
        kick(32'hFFFF_FFFE, 16'd2);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            observe();
        end
        checks++;
        if (hs_addr.size() != 2) begin
            errors++; $display("FAIL wrap_count got %0d want 2", hs_addr.size());
        end else begin
            checks++;
            if (hs_addr[0] !== 32'hFFFF_FFFC || hs_data[0] !== 32'h3FFF_FFF9) begin
                errors++; $display("FAIL wrap_w0 got %h/%h want fffffffc/3ffffff9", hs_addr[0], hs_data[0]);
            end
            checks++;
            if (hs_addr[1] !== 32'h0 || hs_data[1] !== 32'hFFFF_FFFA) begin
                errors++; $display("FAIL wrap_w1 got %h/%h want 00000000/fffffffa", hs_addr[1], hs_data[1]);
            end
        end
    endtask

    task automatic test_abort_restart();
        bit hit;
        hit = 1'b0;
        dout_ready = 1'b1;
        kick(32'h200, 16'd4);
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) begin
                // start while busy must be ignored
                start = 1'b1; base_addr = 32'h999; word_count = 16'd7;
            end
            if (dout_valid && dout_addr == 32'h204) begin
                dout_ready = 1'b0;
                reset = 1'b1;
                hit = 1'b1;
            end
            observe();
        end
        checks++;
        if (!hit || hs_addr.size() != 1 || hs_addr[0] !== 32'h200) begin
            errors++; $display("FAIL abort_reach got hit=%0d words=%0d want 1/1 at 00000200", hit, hs_addr.size());
        end
        @(negedge clk);
        checks++;
        if ({cpu_hold, dout_valid, busy, done} !== 4'b0 || rd_addr !== 32'd0 || dout_data !== 32'd0 || dout_addr !== 32'd0) begin
            errors++;
            $display("FAIL abort_outputs got hold=%b valid=%b busy=%b done=%b rd=%h d=%h a=%h want all 0",
                     cpu_hold, dout_valid, busy, done, rd_addr, dout_data, dout_addr);
        end
        checks++;
        if (done_cnt != 0) begin
            errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt);
        end
        reset = 1'b0;
        dout_ready = 1'b1;
        kick(32'h300, 16'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            observe();
        end
        checks++;
        if (hs_addr.size() != 1 || done_cnt != 1) begin
            errors++; $display("FAIL restart_count got words=%0d done=%0d want 1/1", hs_addr.size(), done_cnt);
        end else begin
            checks++;
            if (hs_addr[0] !== 32'h300 || hs_data[0] !== 32'hBA) begin
                errors++; $display("FAIL restart_word got %h/%h want 00000300/000000ba", hs_addr[0], hs_data[0]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; dout_ready = 1'b0;
        clear_obs();
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_wrap();
        test_abort_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
